// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: grant held until DONE or owner withdraws.
// Define ARB_TIMEOUT_EN to force release after MAX_HOLD cycles with a TIMEOUT pulse.
module rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [N-1:0]         REQ,
  input  logic                 DONE,
  output logic [N-1:0]         GNT,
  output logic                 GNT_VLD,
  output logic [$clog2(N)-1:0] GNT_ID,
  output logic                 TIMEOUT
);

  localparam int ID_W = $clog2(N);

  if (N < 2 || MAX_HOLD < 1) begin : g_cfg_err
    $error("rr_arbiter: N must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [N-1:0]     r_gnt;
  logic [N-1:0]     w_gnt_nxt;
  logic             r_vld;
  logic             w_vld_nxt;
  logic [ID_W-1:0]  r_gnt_id;
  logic [ID_W-1:0]  w_gnt_id_nxt;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [ID_W-1:0]  w_pick_id;
  logic             w_found;
  logic             w_release;
  logic             w_force;
  logic             w_to_nxt;

  // Search from r_ptr upward, wrapping at N-1 -> 0.
  always_comb begin : p_pick
    logic [ID_W-1:0] idx;
    w_found   = 1'b0;
    w_pick_id = '0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = ID_W'((int'(r_ptr) + i) % N);
      if (!w_found && REQ[idx]) begin
        w_found   = 1'b1;
        w_pick_id = idx;
      end
    end
  end

  assign w_release = DONE || !REQ[r_gnt_id];

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_to_nxt;
      if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // Normal release wins over a forced one in the same cycle.
  assign w_force = (r_state == BUSY)
                && (r_cnt == CNT_W'(MAX_HOLD - 1))
                && !w_release;
  assign TIMEOUT = r_timeout;
`else
  assign w_force = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_gnt_nxt    = r_gnt;
    w_vld_nxt    = r_vld;
    w_gnt_id_nxt = r_gnt_id;
    w_ptr_nxt    = r_ptr;
    w_to_nxt     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_gnt_nxt            = '0;
          w_gnt_nxt[w_pick_id] = 1'b1;
          w_vld_nxt            = 1'b1;
          w_gnt_id_nxt         = w_pick_id;
          w_state_nxt          = BUSY;
        end
      end
      BUSY: begin
        if (w_release || w_force) begin
          w_gnt_nxt    = '0;
          w_vld_nxt    = 1'b0;
          w_gnt_id_nxt = '0;
          w_to_nxt     = w_force;
          w_state_nxt  = IDLE;
          if (r_gnt_id == ID_W'(N - 1)) begin
            w_ptr_nxt = '0;
          end else begin
            w_ptr_nxt = r_gnt_id + 1'b1;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_vld    <= 1'b0;
      r_gnt_id <= '0;
      r_ptr    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_vld    <= w_vld_nxt;
      r_gnt_id <= w_gnt_id_nxt;
      r_ptr    <= w_ptr_nxt;
    end
  end

  assign GNT     = r_gnt;
  assign GNT_VLD = r_vld;
  assign GNT_ID  = r_gnt_id;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter (N=4, MAX_HOLD=16).
// Timeout steps run only when ARB_TIMEOUT_EN is defined.
module tb_rr_arbiter;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic [N-1:0] REQ;
  logic         DONE;
  logic [N-1:0] GNT;
  logic         GNT_VLD;
  logic [1:0]   GNT_ID;
  logic         TIMEOUT;

  int errs   = 0;
  int checks = 0;

  rr_arbiter #(.N(N), .MAX_HOLD(16)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .REQ     (REQ),
    .DONE    (DONE),
    .GNT     (GNT),
    .GNT_VLD (GNT_VLD),
    .GNT_ID  (GNT_ID),
    .TIMEOUT (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk1(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag,
                     input logic [3:0] eg,
                     input logic [1:0] eid,
                     input logic       eto);
    chk1({tag, ".gnt"}, 32'(GNT), 32'(eg));
    chk1({tag, ".vld"}, 32'(GNT_VLD), 32'(|eg));
    chk1({tag, ".id"}, 32'(GNT_ID), 32'(eid));
    chk1({tag, ".to"}, 32'(TIMEOUT), 32'(eto));
  endtask

  logic [3:0] rot_g [4];
  logic [1:0] rot_i [4];

  initial begin
    rot_g[0] = 4'b0010; rot_i[0] = 2'd1;
    rot_g[1] = 4'b0100; rot_i[1] = 2'd2;
    rot_g[2] = 4'b1000; rot_i[2] = 2'd3;
    rot_g[3] = 4'b0001; rot_i[3] = 2'd0;

    RST  = 1'b1;
    REQ  = 4'b1111;
    DONE = 1'b0;

    // 1: reset held 3 cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_hold", 4'b0000, 2'd0, 1'b0);
    end
    RST = 1'b0;
    tick();
    chk("first_gnt", 4'b0001, 2'd0, 1'b0);

    // 2: rotation with DONE pulses
    for (int k = 0; k < 4; k++) begin
      DONE = 1'b1;
      tick();
      DONE = 1'b0;
      chk("rot_bubble", 4'b0000, 2'd0, 1'b0);
      tick();
      chk("rot_gnt", rot_g[k], rot_i[k], 1'b0);
    end

    // 3: no preemption; PTR=1 after withdraw of 0
    REQ = 4'b0000;
    tick();
    chk("withdraw0", 4'b0000, 2'd0, 1'b0);
    REQ = 4'b0100;
    tick();
    chk("gnt2", 4'b0100, 2'd2, 1'b0);
    REQ = 4'b0101;
    tick();
    chk("nopreempt_a", 4'b0100, 2'd2, 1'b0);
    tick();
    chk("nopreempt_b", 4'b0100, 2'd2, 1'b0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    chk("rel2", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("wrap_to0", 4'b0001, 2'd0, 1'b0);

    // 4: requester 3 withdraws; PTR wraps to 0
    REQ = 4'b1000;
    tick();
    chk("rel0", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("gnt3", 4'b1000, 2'd3, 1'b0);
    REQ = 4'b0011;
    tick();
    chk("drop3", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("ptr_wrap", 4'b0001, 2'd0, 1'b0);

    // 5: reset while holding 0010
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    chk("rel0b", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("gnt1", 4'b0010, 2'd1, 1'b0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst_busy", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("ptr_rst", 4'b0001, 2'd0, 1'b0);

    // DONE in IDLE is ignored
    REQ = 4'b0000;
    tick();
    chk("rel_idle", 4'b0000, 2'd0, 1'b0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    chk("done_idle", 4'b0000, 2'd0, 1'b0);

    // DONE with a new REQ in the same cycle: bubble first
    REQ = 4'b0100;
    tick();
    chk("gnt2b", 4'b0100, 2'd2, 1'b0);
    REQ  = 4'b0110;
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    chk("done_newreq", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("after_bubble", 4'b0010, 2'd1, 1'b0);
    REQ = 4'b0000;
    tick();
    chk("clear", 4'b0000, 2'd0, 1'b0);

    // 6: hold behaviour with REQ[1] only, PTR=2
    REQ = 4'b0010;
    tick();
    chk("hold_gnt", 4'b0010, 2'd1, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("hold", 4'b0010, 2'd1, 1'b0);
    end
    tick();
    chk("timeout", 4'b0000, 2'd0, 1'b1);
    tick();
    chk("regrant", 4'b0010, 2'd1, 1'b0);
    for (int i = 1; i < 16; i++) begin
      tick();
    end
    chk("last_hold", 4'b0010, 2'd1, 1'b0);
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
    chk("done_wins", 4'b0000, 2'd0, 1'b0);
    tick();
    chk("after_done", 4'b0010, 2'd1, 1'b0);
`else
    for (int i = 0; i < 24; i++) begin
      tick();
    end
    chk("hold_forever", 4'b0010, 2'd1, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
